// File: rtl/uart_cmd_ctrl.sv
// UART command-frame decoder: SYNC, ADDR, DATA_HI, DATA_LO, CHK -> one register write.
// Address 0x00 additionally reconfigures the receiver word size when the value is legal.
//   state    | meaning
//   S_IDLE   | waiting for SYNC_BYTE, timer cleared
//   S_ADDR   | waiting for address byte
//   S_DHI    | waiting for data high byte
//   S_DLO    | waiting for data low byte
//   S_CHK    | waiting for checksum byte
//   S_COMMIT | write strobe cycle; behaves as IDLE for incoming bytes
module uart_cmd_ctrl #(
  parameter int          MAX_WORD_SIZE  = 8,
  parameter int          TIMEOUT_CYCLES = 1000,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [MAX_WORD_SIZE-1:0] rx_word,
  input  logic                     rx_done,
  output logic [5:0]               rx_bits,
  output logic [7:0]               reg_addr,
  output logic [15:0]              reg_data,
  output logic                     reg_we,
  output logic                     busy,
  output logic                     err_chk,
  output logic                     err_timeout
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [5:0] MAX_BITS = 6'(MAX_WORD_SIZE);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DHI, S_DLO, S_CHK, S_COMMIT} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       addr_q, addr_d, dhi_q, dhi_d, dlo_q, dlo_d;
  logic [5:0]       rx_bits_q, rx_bits_d;
  logic [7:0]       reg_addr_q, reg_addr_d;
  logic [15:0]      reg_data_q, reg_data_d;
  logic             reg_we_q, reg_we_d, busy_q, busy_d;
  logic             err_chk_q, err_chk_d, err_to_q, err_to_d;

  logic [7:0] rx_byte;
  logic [7:0] sum;
  logic       cfg_ok;
  logic       unused_rx;

  // Only the low byte carries frame data; the upper word bits are deliberately ignored.
  assign unused_rx = ^rx_word;
  assign rx_byte   = rx_word[7:0];
  assign sum       = addr_q + dhi_q + dlo_q;
  assign cfg_ok    = (dlo_q[5:0] >= 6'd5) && (dlo_q[5:0] <= MAX_BITS);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    dhi_d      = dhi_q;
    dlo_d      = dlo_q;
    rx_bits_d  = rx_bits_q;
    reg_addr_d = reg_addr_q;
    reg_data_d = reg_data_q;
    reg_we_d   = 1'b0;
    err_chk_d  = 1'b0;
    err_to_d   = 1'b0;

    case (state_q)
      S_IDLE, S_COMMIT: begin
        cnt_d   = '0;
        state_d = (rx_done && rx_byte == SYNC_BYTE) ? S_ADDR : S_IDLE;
      end
      default: begin
        if (rx_done) begin
          cnt_d = '0;
          case (state_q)
            S_ADDR: begin addr_d = rx_byte; state_d = S_DHI; end
            S_DHI:  begin dhi_d  = rx_byte; state_d = S_DLO; end
            S_DLO:  begin dlo_d  = rx_byte; state_d = S_CHK; end
            default: begin
              if (rx_byte == sum) begin
                state_d    = S_COMMIT;
                reg_we_d   = 1'b1;
                reg_addr_d = addr_q;
                reg_data_d = {dhi_q, dlo_q};
                if (addr_q == 8'h00) begin
                  if (cfg_ok) rx_bits_d = dlo_q[5:0];
                  else        err_chk_d = 1'b1;
                end
              end else begin
                state_d   = S_IDLE;
                err_chk_d = 1'b1;
              end
            end
          endcase
        end else if (cnt_q == CNT_LAST) begin
          cnt_d    = '0;
          state_d  = S_IDLE;
          err_to_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      dhi_q      <= '0;
      dlo_q      <= '0;
      rx_bits_q  <= 6'd8;
      reg_addr_q <= '0;
      reg_data_q <= '0;
      reg_we_q   <= 1'b0;
      busy_q     <= 1'b0;
      err_chk_q  <= 1'b0;
      err_to_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      dhi_q      <= dhi_d;
      dlo_q      <= dlo_d;
      rx_bits_q  <= rx_bits_d;
      reg_addr_q <= reg_addr_d;
      reg_data_q <= reg_data_d;
      reg_we_q   <= reg_we_d;
      busy_q     <= busy_d;
      err_chk_q  <= err_chk_d;
      err_to_q   <= err_to_d;
    end
  end

  assign rx_bits     = rx_bits_q;
  assign reg_addr    = reg_addr_q;
  assign reg_data    = reg_data_q;
  assign reg_we      = reg_we_q;
  assign busy        = busy_q;
  assign err_chk     = err_chk_q;
  assign err_timeout = err_to_q;

endmodule
